// File: rtl/can_crc_engine.sv
//==============================================================================
// Module   : can_crc_engine
// Brief    : Parametrised CAN CRC engine with accumulate/hold/serial-out FSM.
//            Optional registered compare against crc_exp: CAN_CRC_CHK_EN.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module can_crc_engine #(
    parameter int               U_DLY = 1,
    parameter int               CRC_W = 15,
    parameter logic [CRC_W-1:0] POLY  = 15'h4599,
    parameter logic [CRC_W-1:0] INIT  = '0,
    parameter int               DIN_W = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             initialize,
    input  logic             din_vld,
    input  logic [DIN_W-1:0] din,
    input  logic             din_last,
    output logic [CRC_W-1:0] crc,
    output logic             crc_rdy,
    output logic             crc_zero,
    input  logic             ser_req,
    input  logic             ser_en,
    output logic             ser_bit,
    output logic             ser_vld,
    output logic             ser_done,
`ifdef CAN_CRC_CHK_EN
    input  logic [CRC_W-1:0] crc_exp,
`endif
    output logic             crc_err
);

    localparam int               c_cnt_w   = $clog2(CRC_W);
    localparam logic [c_cnt_w-1:0] c_cnt_top = c_cnt_w'(CRC_W - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_calc  = 2'd1;
    localparam logic [1:0] c_st_hold  = 2'd2;
    localparam logic [1:0] c_st_shift = 2'd3;

    // U_DLY is retained for drop-in compatibility; synthesizable code applies no delay.
    if (CRC_W < 8 || CRC_W > 32 || DIN_W < 1 || DIN_W > 8 || U_DLY < 0) begin : g_bad_param
        $error("can_crc_engine: parameter out of range");
    end

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [CRC_W-1:0]   r_crc;
    logic [CRC_W-1:0]   w_crc_nxt;
    logic [CRC_W-1:0]   w_beat;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic               r_done;
    logic               w_done_nxt;

    function automatic logic [CRC_W-1:0] f_crc_step(input logic [CRC_W-1:0] c, input logic b);
        logic [CRC_W-1:0] s;
        s = {c[CRC_W-2:0], 1'b0};
        return (b ^ c[CRC_W-1]) ? (s ^ POLY) : s;
    endfunction

    // MSB of din is the earliest bit on the wire.
    always_comb begin
        w_beat = r_crc;
        for (int i = DIN_W - 1; i >= 0; i--) begin
            w_beat = f_crc_step(w_beat, din[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || initialize) begin
            r_state <= c_st_idle;
            r_crc   <= INIT;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_crc   <= w_crc_nxt;
            r_cnt   <= w_cnt_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_crc_nxt   = r_crc;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = 1'b0;
        case (r_state)
            c_st_idle, c_st_calc: begin
                if (din_vld) begin
                    w_crc_nxt   = w_beat;
                    w_state_nxt = din_last ? c_st_hold : c_st_calc;
                end
            end
            c_st_hold: begin
                if (ser_req) begin
                    w_state_nxt = c_st_shift;
                    w_cnt_nxt   = c_cnt_top;
                end
            end
            c_st_shift: begin
                if (ser_en) begin
                    if (r_cnt == '0) begin
                        w_state_nxt = c_st_idle;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt - c_cnt_one;
                    end
                end
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    assign crc      = r_crc;
    assign crc_rdy  = (r_state == c_st_hold);
    assign crc_zero = (r_state == c_st_hold) && (r_crc == '0);
    assign ser_vld  = (r_state == c_st_shift);
    assign ser_bit  = (r_state == c_st_shift) ? r_crc[r_cnt] : 1'b0;
    assign ser_done = r_done;

`ifdef CAN_CRC_CHK_EN
    logic r_err;
    logic w_hold_entry;

    assign w_hold_entry = ((r_state == c_st_idle) || (r_state == c_st_calc)) && din_vld && din_last;

    // Compare the value being loaded into HOLD, so the flag is valid alongside crc_rdy.
    always_ff @(posedge clk) begin
        if (rst || initialize) begin
            r_err <= 1'b0;
        end else if (w_hold_entry) begin
            r_err <= (w_beat != crc_exp);
        end
    end

    assign crc_err = r_err;
`else
    assign crc_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_can_crc_engine.sv
//==============================================================================
// Module   : tb_can_crc_engine
// Brief    : Directed self-checking bench for can_crc_engine (CRC-15, 1 and 2 bits/beat).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_can_crc_engine;

    logic        clk;
    logic        rst;
    logic        initialize;
    logic        din_vld;
    logic [0:0]  din;
    logic        din_last;
    logic [14:0] crc;
    logic        crc_rdy;
    logic        crc_zero;
    logic        ser_req;
    logic        ser_en;
    logic        ser_bit;
    logic        ser_vld;
    logic        ser_done;
    logic        crc_err;

    logic        din_vld2;
    logic [1:0]  din2;
    logic        din_last2;
    logic [14:0] crc2;
    logic        crc_rdy2;
    logic        crc_zero2;
    logic        ser_req2;
    logic        ser_en2;
    logic        ser_bit2;
    logic        ser_vld2;
    logic        ser_done2;
    logic        crc_err2;
`ifdef CAN_CRC_CHK_EN
    logic [14:0] crc_exp;
    logic [14:0] crc_exp2;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    can_crc_engine u_dut (
        .clk        (clk),
        .rst        (rst),
        .initialize (initialize),
        .din_vld    (din_vld),
        .din        (din),
        .din_last   (din_last),
        .crc        (crc),
        .crc_rdy    (crc_rdy),
        .crc_zero   (crc_zero),
        .ser_req    (ser_req),
        .ser_en     (ser_en),
        .ser_bit    (ser_bit),
        .ser_vld    (ser_vld),
        .ser_done   (ser_done),
`ifdef CAN_CRC_CHK_EN
        .crc_exp    (crc_exp),
`endif
        .crc_err    (crc_err)
    );

    can_crc_engine #(.DIN_W(2)) u_dut2 (
        .clk        (clk),
        .rst        (rst),
        .initialize (initialize),
        .din_vld    (din_vld2),
        .din        (din2),
        .din_last   (din_last2),
        .crc        (crc2),
        .crc_rdy    (crc_rdy2),
        .crc_zero   (crc_zero2),
        .ser_req    (ser_req2),
        .ser_en     (ser_en2),
        .ser_bit    (ser_bit2),
        .ser_vld    (ser_vld2),
        .ser_done   (ser_done2),
`ifdef CAN_CRC_CHK_EN
        .crc_exp    (crc_exp2),
`endif
        .crc_err    (crc_err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference CRC-15 step, used only to build the residue stimulus.
    function automatic logic [14:0] crc15(input logic [14:0] c, input logic b);
        logic [14:0] s;
        s = {c[13:0], 1'b0};
        return (b ^ c[14]) ? (s ^ 15'h4599) : s;
    endfunction

    task automatic feed(input logic b, input logic last);
        din_vld  = 1'b1;
        din      = b;
        din_last = last;
        @(negedge clk);
        din_vld  = 1'b0;
        din_last = 1'b0;
    endtask

    task automatic pulse_init();
        initialize = 1'b1;
        @(negedge clk);
        initialize = 1'b0;
    endtask

    task automatic run_residue();
        logic [14:0] c;
        logic [18:0] msg;
        c   = '0;
        msg = 19'h5A3C7;
        pulse_init();
        for (int i = 18; i >= 0; i--) c = crc15(c, msg[i]);
        for (int i = 18; i >= 0; i--) feed(msg[i], 1'b0);
        for (int i = 14; i >= 0; i--) feed(c[i], i == 0);
        check("res_crc",  32'(crc), 32'h0);
        check("res_zero", 32'(crc_zero), 32'h1);
        check("res_rdy",  32'(crc_rdy), 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [14:0] exp_crc;
        int          done_cnt;

        rst        = 1'b1;
        initialize = 1'b0;
        din_vld    = 1'b0;
        din        = '0;
        din_last   = 1'b0;
        ser_req    = 1'b0;
        ser_en     = 1'b0;
        din_vld2   = 1'b0;
        din2       = '0;
        din_last2  = 1'b0;
        ser_req2   = 1'b0;
        ser_en2    = 1'b0;
`ifdef CAN_CRC_CHK_EN
        crc_exp    = '0;
        crc_exp2   = '0;
`endif
        repeat (3) @(negedge clk);
        check("rst_crc",     32'(crc), 32'h0);
        check("rst_rdy",     32'(crc_rdy), 32'h0);
        check("rst_zero",    32'(crc_zero), 32'h0);
        check("rst_ser_vld", 32'(ser_vld), 32'h0);
        check("rst_ser_bit", 32'(ser_bit), 32'h0);
        check("rst_done",    32'(ser_done), 32'h0);
        check("rst_err",     32'(crc_err), 32'h0);
        rst = 1'b0;

        // Single bit 1 from INIT=0 gives the polynomial itself
        feed(1'b1, 1'b1);
        check("one_crc",  32'(crc), 32'h4599);
        check("one_rdy",  32'(crc_rdy), 32'h1);
        check("one_zero", 32'(crc_zero), 32'h0);

        pulse_init();
        check("init_crc", 32'(crc), 32'h0);
        check("init_rdy", 32'(crc_rdy), 32'h0);

        // Bits 1,0 serially; the 2-bit instance takes 2'b10 as one beat
        feed(1'b1, 1'b0);
        check("two_mid_crc", 32'(crc), 32'h4599);
        check("two_mid_rdy", 32'(crc_rdy), 32'h0);
        din_vld2  = 1'b1;
        din2      = 2'b10;
        din_last2 = 1'b1;
        feed(1'b0, 1'b1);
        din_vld2  = 1'b0;
        din_last2 = 1'b0;
        check("two_crc",  32'(crc), 32'h4EAB);
        check("two_rdy",  32'(crc_rdy), 32'h1);
        check("w2_crc",   32'(crc2), 32'h4EAB);
        check("w2_rdy",   32'(crc_rdy2), 32'h1);

        // din_vld while in HOLD is ignored
        feed(1'b1, 1'b1);
        check("hold_din_crc", 32'(crc), 32'h4EAB);
        check("hold_din_rdy", 32'(crc_rdy), 32'h1);

        // Serial shift-out, ser_en every third cycle
        ser_req = 1'b1;
        @(negedge clk);
        ser_req  = 1'b0;
        exp_crc  = 15'h4EAB;
        done_cnt = 0;
        for (int i = 14; i >= 0; i--) begin
            check("ser_vld", 32'(ser_vld), 32'h1);
            check($sformatf("ser_bit%0d", i), 32'(ser_bit), 32'(exp_crc[i]));
            done_cnt += int'(ser_done);
            @(negedge clk);
            done_cnt += int'(ser_done);
            @(negedge clk);
            done_cnt += int'(ser_done);
            ser_en = 1'b1;
            @(negedge clk);
            ser_en = 1'b0;
        end
        check("ser_early_done", 32'(done_cnt), 32'h0);
        check("ser_done",       32'(ser_done), 32'h1);
        check("ser_end_vld",    32'(ser_vld), 32'h0);
        check("ser_end_crc",    32'(crc), 32'h4EAB);
        check("ser_end_rdy",    32'(crc_rdy), 32'h0);
        @(negedge clk);
        check("ser_done_off",   32'(ser_done), 32'h0);

        // Message followed by its own CRC leaves a zero residue
`ifdef CAN_CRC_CHK_EN
        crc_exp = 15'h0;
        run_residue();
        check("res_err_match", 32'(crc_err), 32'h0);
        crc_exp = 15'h1;
        run_residue();
        check("res_err_miss", 32'(crc_err), 32'h1);
        pulse_init();
        check("err_cleared", 32'(crc_err), 32'h0);
`else
        run_residue();
        check("res_err_tied", 32'(crc_err), 32'h0);
`endif

        // ser_req in CALC is ignored
        pulse_init();
        feed(1'b1, 1'b0);
        ser_req = 1'b1;
        @(negedge clk);
        ser_req = 1'b0;
        check("calc_req_crc", 32'(crc), 32'h4599);
        check("calc_req_vld", 32'(ser_vld), 32'h0);
        check("calc_req_rdy", 32'(crc_rdy), 32'h0);
        feed(1'b0, 1'b1);
        check("calc_fin_crc", 32'(crc), 32'h4EAB);
        check("calc_fin_rdy", 32'(crc_rdy), 32'h1);

        // initialize while shifting, at count 7
        ser_req = 1'b1;
        @(negedge clk);
        ser_req = 1'b0;
        ser_en  = 1'b1;
        repeat (7) @(negedge clk);
        check("shift7_vld", 32'(ser_vld), 32'h1);
        check("shift7_bit", 32'(ser_bit), 32'h1);
        initialize = 1'b1;
        @(negedge clk);
        initialize = 1'b0;
        ser_en     = 1'b0;
        check("sinit_crc",  32'(crc), 32'h0);
        check("sinit_vld",  32'(ser_vld), 32'h0);
        check("sinit_done", 32'(ser_done), 32'h0);
        check("sinit_rdy",  32'(crc_rdy), 32'h0);
        @(negedge clk);
        check("sinit_done2", 32'(ser_done), 32'h0);

        // IDLE continues from the held value, then rst beats din_vld
        feed(1'b1, 1'b0);
        check("idle_crc", 32'(crc), 32'h4599);
        rst = 1'b1;
        feed(1'b1, 1'b1);
        rst = 1'b0;
        check("rstd_crc", 32'(crc), 32'h0);
        check("rstd_rdy", 32'(crc_rdy), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
